mem_access_unit: RTL and testbench

- Initiator side of the word-addressed data memory interface. It accepts byte, halfword and word load/store requests from the CPU datapath over a valid/ready handshake, and drives the memory's address, write-data and write-enable.
- The memory side has a combinational read and a synchronous write, indexed by addr[31:2].
- Sub-word stores are done as read-modify-write. Loads are extracted and sign/zero-extended.
- The returned response carries data or an error.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_access_unit_lane_align.sv | 35 +++
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 tb/tb_mem_access_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access path: request sizes, FSM states
// and the default data-memory depth also used by the memory itself.
package mem_pkg;

    localparam int DEF_DATA_MEM_SIZE = 64;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } mau_state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        return ((size == SZ_HALF) && lsb[0]) || ((size == SZ_WORD) && (lsb != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
module lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic [31:0] wdata,
    input  logic [1:0]  lsb,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_in[{lsb, 3'b000} +: 8];
        half_sel = word_in[{lsb[1], 4'b0000} +: 16];

        case (size)
            SZ_BYTE: load_data = {{24{sgn & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{sgn & half_sel[15]}}, half_sel};
            default: load_data = word_in;
        endcase

        merged = word_in;
        case (size)
            SZ_BYTE: merged[{lsb, 3'b000} +: 8]      = wdata[7:0];
            SZ_HALF: merged[{lsb[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-addressed data memory; sub-word stores are
// performed as read-modify-write.
//
// state | meaning
// IDLE  | ready for a request
// RD    | memory word addressed; load capture or store merge on next edge
// WR    | memory write strobe active for this one cycle
// RESP  | response held until resp_ready
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_MEM_SIZE = DEF_DATA_MEM_SIZE,
    parameter int ADDR_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    output logic              mem_write,
    input  logic [31:0]       mem_read_data
);

    mau_state_e        state_q, state_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic              write_q, write_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              req_err;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    lane_align u_lane_align (
        .word_in   (mem_read_data),
        .wdata     (wdata_q),
        .lsb       (addr_lo_q),
        .size      (size_q),
        .sgn       (signed_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_comb begin
        req_err = (req_size == 2'd3)
                || is_misaligned(req_size, req_addr[1:0])
                || (req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DATA_MEM_SIZE));

        state_d     = state_q;
        addr_lo_d   = addr_lo_q;
        size_d      = size_q;
        signed_d    = signed_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_lo_d   = req_addr[1:0];
                    size_d      = req_size;
                    signed_d    = req_signed;
                    write_d     = req_write;
                    wdata_d     = req_wdata;
                    resp_data_d = 32'h0;
                    resp_err_d  = req_err;
                    if (req_err) begin
                        state_d = RESP;
                    end else begin
                        mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                        // Full-word stores need no old data, so they skip the read.
                        if (req_write && (req_size == SZ_WORD)) begin
                            mem_wdata_d = req_wdata;
                            state_d     = WR;
                        end else begin
                            state_d = RD;
                        end
                    end
                end
            end
            RD: begin
                if (write_q) begin
                    mem_wdata_d = merged;
                    state_d     = WR;
                end else begin
                    resp_data_d = load_data;
                    state_d     = RESP;
                end
            end
            WR: begin
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_lo_q   <= 2'b00;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= 32'h0;
            resp_data_q <= 32'h0;
            resp_err_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            addr_lo_q   <= addr_lo_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Handshake and strobe outputs decode the registered state only.
    assign req_ready      = (state_q == IDLE);
    assign resp_valid     = (state_q == RESP);
    assign mem_write      = (state_q == WR);
    assign resp_data      = resp_data_q;
    assign resp_err       = resp_err_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model with a per-cycle compare
// process, a 64-word memory, and literal checks on key results.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic [31:0] mem_read_data;

    mem_access_unit dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_err       (resp_err),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    logic [31:0] model_mem [64];

    assign mem_read_data = (mem_addr[31:8] == 24'h0) ? mem[mem_addr[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_write && (mem_addr[31:8] == 24'h0))
            mem[mem_addr[7:2]] <= mem_write_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    bit          check_en = 1'b0;
    bit          busy = 1'b0;
    int          acc_cyc = 0;
    int          exp_lat = 0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_data = 32'h0;
    logic        exp_wr = 1'b0;
    logic [31:0] exp_waddr = 32'h0;
    logic [31:0] exp_wword = 32'h0;
    logic [31:0] last_data = 32'h0;
    logic        last_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outcome of one request, derived from the memory contents.
    function automatic void model(input logic w, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] wd);
        int unsigned idx;
        int unsigned sh;
        logic [31:0] old;
        logic [31:0] lane;
        logic [31:0] mask;
        idx = a >> 2;
        sh  = (a % 4) * 8;
        exp_err   = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0)
                 || (sz == 2'd2 && (a % 4) != 0) || (idx >= 64);
        exp_data  = 32'h0;
        exp_wr    = 1'b0;
        exp_waddr = a & ~32'h3;
        exp_wword = 32'h0;
        if (exp_err) begin
            exp_lat = 1;
            return;
        end
        old  = model_mem[idx];
        mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        if (!w) begin
            exp_lat = 2;
            lane = (old >> sh) & mask;
            if (sg && sz == 2'd0 && lane >= 32'd128)   lane = lane - 32'd256;
            if (sg && sz == 2'd1 && lane >= 32'd32768) lane = lane - 32'd65536;
            exp_data = lane;
        end else begin
            exp_wr    = 1'b1;
            exp_lat   = (sz == 2'd2) ? 2 : 3;
            exp_wword = (old & ~(mask << sh)) | ((wd & mask) << sh);
            model_mem[idx] = exp_wword;
        end
    endfunction

    always @(negedge clk) begin
        int  delta;
        bit  exp_rv;
        bit  exp_mw;
        if (check_en && rst) begin
            delta  = cyc - acc_cyc;
            exp_rv = busy && (delta >= exp_lat - 1);
            exp_mw = busy && exp_wr && (delta == exp_lat - 2);
            chk("req_ready", {31'b0, req_ready}, {31'b0, !busy});
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_rv});
            chk("mem_write", {31'b0, mem_write}, {31'b0, exp_mw});
            if (exp_rv) begin
                chk("resp_data", resp_data, exp_data);
                chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
            end
            if (busy && !exp_err && delta < exp_lat - 1)
                chk("mem_addr", mem_addr, exp_waddr);
            if (exp_mw)
                chk("mem_write_data", mem_write_data, exp_wword);
        end
    end

    // Called at posedge+1 with the unit idle; returns at posedge+1 after the
    // response handshake edge. hold = response cycles seen with resp_ready low.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int hold, input bit keep_valid);
        int  seen;
        bit  done;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        model(w, sz, sg, a, wd);
        acc_cyc = cyc;
        busy    = 1'b1;
        if (!keep_valid) begin
            req_valid = 1'b0;
            req_write = ~w;
            req_size  = 2'd3;
            req_addr  = 32'hFFFF_FFFF;
            req_wdata = 32'hA5A5_A5A5;
        end
        if (hold > 0) resp_ready = 1'b0;
        seen = 0;
        done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                seen++;
                if (seen > hold) begin
                    last_data  = resp_data;
                    last_err   = resp_err;
                    resp_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    busy = 1'b0;
                    done = 1'b1;
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got no response want response for addr 0x%08h", a);
            resp_ready = 1'b1;
            busy = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]       = 32'h0;
            model_mem[i] = 32'h0;
        end
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_mem_write", {31'b0, mem_write}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_en = 1'b1;

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, 1'b0);
        chk("lit_mem_0x10", mem[4], 32'hDEAD_BEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0);
        chk("lit_word_load", last_data, 32'hDEAD_BEEF);
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, 1'b0);
        chk("lit_sbyte_13", last_data, 32'hFFFF_FFDE);
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, 1'b0);
        chk("lit_ubyte_13", last_data, 32'h0000_00DE);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0, 1'b0);
        chk("lit_uhalf_12", last_data, 32'h0000_DEAD);
        do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 0, 1'b0);
        chk("lit_shalf_10", last_data, 32'hFFFF_BEEF);

        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFF_FF5A, 0, 1'b0);
        chk("lit_byte_store", mem[4], 32'hDEAD_5AEF);
        do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234_5678, 0, 1'b0);
        chk("lit_half_store", mem[4], 32'h5678_5AEF);
        do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 0, 1'b0);
        chk("lit_sbyte_11", last_data, 32'h0000_005A);

        do_req(1'b0, 2'd2, 1'b0, 32'h0A, 32'h0, 0, 1'b0);
        chk("lit_err_misword", {31'b0, last_err}, 32'h1);
        do_req(1'b1, 2'd1, 1'b0, 32'h21, 32'hFFFF, 0, 1'b0);
        chk("lit_err_mishalf", {31'b0, last_err}, 32'h1);
        chk("lit_err_nowrite", mem[8], 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 1'b0);
        chk("lit_err_range", {31'b0, last_err}, 32'h1);
        do_req(1'b0, 2'd3, 1'b0, 32'h04, 32'h0, 0, 1'b0);
        chk("lit_err_size3", {31'b0, last_err}, 32'h1);
        chk("lit_err_data", last_data, 32'h0);

        do_req(1'b1, 2'd2, 1'b0, 32'hFC, 32'hCAFE_F00D, 0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'hFC, 32'h0, 0, 1'b0);
        chk("lit_top_word", last_data, 32'hCAFE_F00D);

        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, 1'b1);
        chk("lit_bp_load", last_data, 32'h5678_5AEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0);

        do_req(1'b1, 2'd2, 1'b0, 32'h14, 32'h1122_3344, 0, 1'b0);
        req_write  = 1'b1;
        req_size   = 2'd1;
        req_signed = 1'b0;
        req_addr   = 32'h14;
        req_wdata  = 32'h0000_FFFF;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_en  = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("arst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("arst_resp_data", resp_data, 32'h0);
        chk("arst_resp_err", {31'b0, resp_err}, 32'h0);
        chk("arst_mem_write", {31'b0, mem_write}, 32'h0);
        chk("arst_mem_addr", mem_addr, 32'h0);
        chk("arst_mem_wdata", mem_write_data, 32'h0);
        @(posedge clk);
        #1;
        chk("arst_mem_write_edge", {31'b0, mem_write}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        chk("lit_mem_0x14_kept", mem[5], 32'h1122_3344);
        do_req(1'b0, 2'd1, 1'b1, 32'h14, 32'h0, 0, 1'b0);
        chk("lit_post_rst_load", last_data, 32'h0000_3344);
        do_req(1'b1, 2'd1, 1'b0, 32'h16, 32'h0000_ABCD, 0, 1'b0);
        chk("lit_post_rst_store", mem[5], 32'hABCD_3344);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
